pipe_stage_elastic: RTL

- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- A single generic pipeline-stage register of configurable width, with a valid/ready handshake on both sides.
- A 2-entry skid buffer keeps in_ready registered, so backpressure never forms a combinational path across stages.
- Adds what plain latches lack: synchronous flush (squash on branch/jump), a configurable bubble value when empty, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_elastic_pkg.sv | 48 ++++
 rtl/pipe_stage_elastic_if.sv | 13 +
 rtl/pipe_stage_elastic_sat_counter.sv | 35 +++
 rtl/pipe_stage_elastic.sv | 110 +++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline stage and the CPU stage payloads.
//   stage_state_e : occupancy state of a pipe_stage_elastic instance
//   ifid_t/idex_t/exmem_t/memwb_t : per-stage payloads carried as DATA_W-wide data
//   NOP_INSTR     : instruction encoding used as the bubble value in the CPU
package pipe_stage_elastic_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_t;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready/data handshake bundle.
//   master : drives valid and data, observes ready
//   slave  : observes valid and data, drives ready
interface pipe_stage_elastic_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter.
//   CLK   : clock
//   RST   : synchronous active-high clear
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage: a main entry plus a skid entry so that
// in_ready depends only on registered state (and RST), never on out_ready.
//   CLK, RST     : clock, synchronous active-high reset
//   flush        : squash all held entries this cycle
//   in_if        : upstream handshake (slave side)
//   out_if       : downstream handshake (master side), data = BUBBLE when empty
//   occupancy    : number of held entries, 0..2
//   stall_count  : saturating count of cycles with out_valid && !out_ready
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned          DATA_W = 32,
  parameter logic [DATA_W-1:0]    BUBBLE = '0,
  parameter int unsigned          CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_count
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic m_valid;
  logic s_valid;
  logic accept;
  logic consume;

  assign m_valid = (state_q == StOne) || (state_q == StFull);
  assign s_valid = (state_q == StFull);

  assign in_if.ready  = !s_valid && !RST;
  assign out_if.valid = m_valid;
  assign out_if.data  = m_valid ? m_data_q : BUBBLE;
  assign occupancy    = {1'b0, m_valid} + {1'b0, s_valid};

  assign accept  = in_if.valid && in_if.ready;
  assign consume = out_if.valid && out_if.ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          m_data_d = in_if.data;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (accept && consume) begin
          m_data_d = in_if.data;
        end else if (accept) begin
          s_data_d = in_if.data;
          state_d  = StFull;
        end else if (consume) begin
          m_data_d = BUBBLE;
          state_d  = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a consume can move us
        if (consume) begin
          m_data_d = s_data_q;
          s_data_d = BUBBLE;
          state_d  = StOne;
        end
      end
      default: begin
        m_data_d = BUBBLE;
        s_data_d = BUBBLE;
        state_d  = StEmpty;
      end
    endcase
    // Flush beats any accept in the same cycle; a consume has already happened downstream
    if (flush) begin
      m_data_d = BUBBLE;
      s_data_d = BUBBLE;
      state_d  = StEmpty;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StEmpty;
      m_data_q <= BUBBLE;
      s_data_q <= BUBBLE;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (m_valid && !out_if.ready),
    .count (stall_count)
  );

endmodule
